axil_cmd_master: RTL and testbench

AXI4-Lite master that turns single-beat register commands into AXI4-Lite read or write transactions. It is the initiator for the register-file AXI slaves in the NTP server targets, and is used where on-FPGA logic must program or poll those slaves (for example board bring-up sequencers, or a PPS-offset writer). Only one transaction is outstanding at a time. A programmable timeout recovers the block if a slave never responds.

---
 rtl/axil_cmd_master.sv | 270 +++++++++++++++++++++++++++
 tb/tb_axil_cmd_master.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns single-beat register commands into AXI4-Lite
// read or write transactions, one outstanding at a time, with a
// programmable per-transaction timeout that abandons an unresponsive slave.
module axil_cmd_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 7,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  // command side
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  // response side
  output logic                              rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              rsp_timeout,
  // AXI4-Lite write address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  // AXI4-Lite write data channel
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  // AXI4-Lite write response channel
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  // AXI4-Lite read address channel
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  // AXI4-Lite read data channel
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;

  // The counter holds k-1 in the k-th cycle after accept; the timeout
  // response is registered, so the decision is taken one cycle before the
  // pulse, i.e. when the counter reaches TIMEOUT_CYCLES-2.
  localparam int              TO_CMP_I     = (TIMEOUT_CYCLES >= 2) ? (TIMEOUT_CYCLES - 2) : 0;
  localparam logic [31:0]     TO_CMP_W     = TO_CMP_I;
  localparam logic [15:0]     TO_CMP       = TO_CMP_W[15:0];
  localparam bit              TO_EN        = (TIMEOUT_CYCLES != 0);
  // With a one-cycle budget the pulse has to be decided at accept time.
  localparam bit              TO_AT_ACCEPT = (TIMEOUT_CYCLES == 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_RESP = 3'd4
  } state_t;

  state_t          state_r,       state_next_s;
  logic            awvalid_r,     awvalid_next_s;
  logic            wvalid_r,      wvalid_next_s;
  logic            bready_r,      bready_next_s;
  logic            arvalid_r,     arvalid_next_s;
  logic            rready_r,      rready_next_s;
  logic [AW-1:0]   addr_r,        addr_next_s;
  logic [DW-1:0]   wdata_r,       wdata_next_s;
  logic [SW-1:0]   wstrb_r,       wstrb_next_s;
  logic            rsp_valid_r,   rsp_valid_next_s;
  logic [DW-1:0]   rsp_rdata_r,   rsp_rdata_next_s;
  logic [1:0]      rsp_resp_r,    rsp_resp_next_s;
  logic            rsp_timeout_r, rsp_timeout_next_s;
  logic [15:0]     cnt_r,         cnt_next_s;

  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, to_fire_s;

  assign aw_hs_s = awvalid_r & M_AXI_AWREADY;
  assign w_hs_s  = wvalid_r  & M_AXI_WREADY;
  assign b_hs_s  = bready_r  & M_AXI_BVALID;
  assign ar_hs_s = arvalid_r & M_AXI_ARREADY;
  assign r_hs_s  = rready_r  & M_AXI_RVALID;

  // Timeout decision; any handshake in the deciding cycle takes priority.
  always_comb begin
    to_fire_s = TO_EN && (state_r != ST_IDLE) && (cnt_r >= TO_CMP) &&
                !(aw_hs_s || w_hs_s || b_hs_s || ar_hs_s || r_hs_s);
  end

  // Next-state and next-output decode for the transaction sequencer.
  always_comb begin
    state_next_s       = state_r;
    awvalid_next_s     = awvalid_r;
    wvalid_next_s      = wvalid_r;
    bready_next_s      = bready_r;
    arvalid_next_s     = arvalid_r;
    rready_next_s      = rready_r;
    addr_next_s        = addr_r;
    wdata_next_s       = wdata_r;
    wstrb_next_s       = wstrb_r;
    rsp_valid_next_s   = 1'b0;
    rsp_rdata_next_s   = rsp_rdata_r;
    rsp_resp_next_s    = rsp_resp_r;
    rsp_timeout_next_s = rsp_timeout_r;
    cnt_next_s         = (state_r == ST_IDLE) ? cnt_r : (cnt_r + 16'd1);

    if (to_fire_s) begin
      // Fault recovery: abandon the slave and report a SLVERR-coded timeout.
      state_next_s       = ST_IDLE;
      awvalid_next_s     = 1'b0;
      wvalid_next_s      = 1'b0;
      bready_next_s      = 1'b0;
      arvalid_next_s     = 1'b0;
      rready_next_s      = 1'b0;
      rsp_valid_next_s   = 1'b1;
      rsp_rdata_next_s   = {DW{1'b0}};
      rsp_resp_next_s    = 2'b10;
      rsp_timeout_next_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_next_s  = cmd_addr;
            wdata_next_s = cmd_wdata;
            wstrb_next_s = cmd_wstrb;
            cnt_next_s   = 16'd0;
            if (TO_AT_ACCEPT) begin
              rsp_valid_next_s   = 1'b1;
              rsp_rdata_next_s   = {DW{1'b0}};
              rsp_resp_next_s    = 2'b10;
              rsp_timeout_next_s = 1'b1;
            end else if (cmd_write) begin
              state_next_s   = ST_WR_REQ;
              awvalid_next_s = 1'b1;
              wvalid_next_s  = 1'b1;
            end else begin
              state_next_s   = ST_RD_REQ;
              arvalid_next_s = 1'b1;
            end
          end else begin
            cnt_next_s = cnt_r;
          end
        end
        ST_WR_REQ: begin
          // AW and W retire independently, in any order.
          if (aw_hs_s) begin
            awvalid_next_s = 1'b0;
          end else begin
            awvalid_next_s = awvalid_r;
          end
          if (w_hs_s) begin
            wvalid_next_s = 1'b0;
          end else begin
            wvalid_next_s = wvalid_r;
          end
          if ((aw_hs_s || !awvalid_r) && (w_hs_s || !wvalid_r)) begin
            state_next_s  = ST_WR_RESP;
            bready_next_s = 1'b1;
          end else begin
            state_next_s = ST_WR_REQ;
          end
        end
        ST_WR_RESP: begin
          if (b_hs_s) begin
            state_next_s       = ST_IDLE;
            bready_next_s      = 1'b0;
            rsp_valid_next_s   = 1'b1;
            rsp_rdata_next_s   = {DW{1'b0}};
            rsp_resp_next_s    = M_AXI_BRESP;
            rsp_timeout_next_s = 1'b0;
          end else begin
            state_next_s = ST_WR_RESP;
          end
        end
        ST_RD_REQ: begin
          if (ar_hs_s) begin
            state_next_s   = ST_RD_RESP;
            arvalid_next_s = 1'b0;
            rready_next_s  = 1'b1;
          end else begin
            state_next_s = ST_RD_REQ;
          end
        end
        ST_RD_RESP: begin
          if (r_hs_s) begin
            state_next_s       = ST_IDLE;
            rready_next_s      = 1'b0;
            rsp_valid_next_s   = 1'b1;
            rsp_rdata_next_s   = M_AXI_RDATA;
            rsp_resp_next_s    = M_AXI_RRESP;
            rsp_timeout_next_s = 1'b0;
          end else begin
            state_next_s = ST_RD_RESP;
          end
        end
        default: begin
          state_next_s   = ST_IDLE;
          awvalid_next_s = 1'b0;
          wvalid_next_s  = 1'b0;
          bready_next_s  = 1'b0;
          arvalid_next_s = 1'b0;
          rready_next_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset abandons any outstanding transaction.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_r       <= ST_IDLE;
      awvalid_r     <= 1'b0;
      wvalid_r      <= 1'b0;
      bready_r      <= 1'b0;
      arvalid_r     <= 1'b0;
      rready_r      <= 1'b0;
      addr_r        <= {AW{1'b0}};
      wdata_r       <= {DW{1'b0}};
      wstrb_r       <= {SW{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_rdata_r   <= {DW{1'b0}};
      rsp_resp_r    <= 2'b00;
      rsp_timeout_r <= 1'b0;
      cnt_r         <= 16'd0;
    end else begin
      state_r       <= state_next_s;
      awvalid_r     <= awvalid_next_s;
      wvalid_r      <= wvalid_next_s;
      bready_r      <= bready_next_s;
      arvalid_r     <= arvalid_next_s;
      rready_r      <= rready_next_s;
      addr_r        <= addr_next_s;
      wdata_r       <= wdata_next_s;
      wstrb_r       <= wstrb_next_s;
      rsp_valid_r   <= rsp_valid_next_s;
      rsp_rdata_r   <= rsp_rdata_next_s;
      rsp_resp_r    <= rsp_resp_next_s;
      rsp_timeout_r <= rsp_timeout_next_s;
      cnt_r         <= cnt_next_s;
    end
  end

  assign cmd_ready     = (state_r == ST_IDLE);
  assign rsp_valid     = rsp_valid_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_resp      = rsp_resp_r;
  assign rsp_timeout   = rsp_timeout_r;
  assign M_AXI_AWADDR  = addr_r;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_r;
  assign M_AXI_WDATA   = wdata_r;
  assign M_AXI_WSTRB   = wstrb_r;
  assign M_AXI_WVALID  = wvalid_r;
  assign M_AXI_BREADY  = bready_r;
  assign M_AXI_ARADDR  = addr_r;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_r;
  assign M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Testbench for axil_cmd_master: a cycle-indexed reference model derives,
// from slave delays alone, which cycles each VALID/READY must be high and
// when the response pulse must appear.
module tb_axil_cmd_master;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [6:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [6:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axil_cmd_master #(
    .C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(7), .TIMEOUT_CYCLES(TO)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic slave_idle();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_resp"}, 32'(rsp_resp), 32'd0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'd0);
    chk({tag, "_valids"}, 32'({awvalid, wvalid, arvalid}), 32'd0);
    chk({tag, "_readies"}, 32'({bready, rready}), 32'd0);
    chk({tag, "_addr"}, 32'({awaddr, araddr}), 32'd0);
    chk({tag, "_wchan"}, wdata ^ 32'(wstrb), 32'd0);
    chk({tag, "_prot"}, 32'({awprot, arprot}), 32'd0);
  endtask

  // Write: AWREADY pulses da cycles after AWVALID rises, WREADY dw cycles
  // after WVALID rises, BVALID db cycles after BREADY rises. Called at a negedge.
  task automatic do_write(input string tag, input logic [6:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int da, input int dw, input int db,
                          input logic [1:0] resp, input bit aw_never);
    int  m, h, end_k, rsp_k, aw_last, w_last;
    bit  to;
    m       = (da > dw) ? da : dw;
    h       = 2 + m + db;
    to      = aw_never || (h > TO - 1);
    end_k   = to ? TO - 1 : h;
    rsp_k   = end_k + 1;
    aw_last = aw_never ? end_k : ((1 + da < end_k) ? 1 + da : end_k);
    w_last  = (1 + dw < end_k) ? 1 + dw : end_k;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    chk({tag, "_cmd_ready_pre"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= rsp_k + 1; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      chk({tag, "_awvalid"}, 32'(awvalid), 32'(k <= aw_last));
      chk({tag, "_wvalid"}, 32'(wvalid), 32'(k <= w_last));
      chk({tag, "_bready"}, 32'(bready), 32'(!aw_never && k >= 2 + m && k <= end_k));
      chk({tag, "_rd_idle"}, 32'({arvalid, rready}), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(k == rsp_k));
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(k >= rsp_k));
      if (k <= aw_last) chk({tag, "_awaddr"}, 32'(awaddr), 32'(addr));
      if (k <= w_last) chk({tag, "_wdata"}, wdata, data);
      if (k <= w_last) chk({tag, "_wstrb"}, 32'(wstrb), 32'(strb));
      if (k >= rsp_k) begin
        chk({tag, "_rsp_resp"}, 32'(rsp_resp), to ? 32'd2 : 32'(resp));
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'(to));
      end
      awready = !aw_never && (k == 1 + da) && (k <= end_k);
      wready  = (k == 1 + dw) && (k <= end_k);
      bvalid  = !aw_never && (k == h) && (k <= end_k);
      bresp   = resp;
    end
    slave_idle();
  endtask

  // Read: ARREADY pulses da cycles after ARVALID rises, RVALID dr cycles
  // after RREADY rises. Called at a negedge.
  task automatic do_read(input string tag, input logic [6:0] addr, input int da, input int dr,
                         input logic [31:0] data, input logic [1:0] resp);
    int h, end_k, rsp_k, ar_last;
    bit to;
    h       = 2 + da + dr;
    to      = (h > TO - 1);
    end_k   = to ? TO - 1 : h;
    rsp_k   = end_k + 1;
    ar_last = (1 + da < end_k) ? 1 + da : end_k;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr;
    cmd_wdata = $urandom; cmd_wstrb = 4'($urandom_range(0, 15));
    chk({tag, "_cmd_ready_pre"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    for (int k = 1; k <= rsp_k + 1; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      chk({tag, "_arvalid"}, 32'(arvalid), 32'(k <= ar_last));
      chk({tag, "_rready"}, 32'(rready), 32'(k >= 2 + da && k <= end_k));
      chk({tag, "_wr_idle"}, 32'({awvalid, wvalid, bready}), 32'd0);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(k == rsp_k));
      chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(k >= rsp_k));
      if (k <= ar_last) chk({tag, "_araddr"}, 32'(araddr), 32'(addr));
      if (k >= rsp_k) begin
        chk({tag, "_rsp_resp"}, 32'(rsp_resp), to ? 32'd2 : 32'(resp));
        chk({tag, "_rsp_rdata"}, rsp_rdata, to ? 32'd0 : data);
        chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 32'(to));
      end
      arready = (k == 1 + da) && (k <= end_k);
      rvalid  = (k == h) && (k <= end_k);
      rdata   = (k == h) ? data : 32'($urandom);
      rresp   = resp;
    end
    slave_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 7'd0; cmd_wdata = 32'd0; cmd_wstrb = 4'd0;
    slave_idle();
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed steps.
    do_write("wr_min", 7'h54, 32'h0000_0005, 4'hF, 0, 0, 0, 2'b00, 1'b0);
    do_write("wr_aw_first", 7'h10, 32'hA5A5_0F0F, 4'h3, 0, 3, 1, 2'b00, 1'b0);
    do_write("wr_w_first", 7'h24, 32'h1234_5678, 4'hC, 2, 0, 0, 2'b01, 1'b0);
    do_read("rd_delay", 7'h3C, 0, 4, 32'hDEAD_BEEF, 2'b00);
    do_read("rd_slverr", 7'h08, 1, 0, 32'h0BAD_F00D, 2'b10);
    do_write("wr_timeout", 7'h40, 32'hCAFE_0001, 4'hF, 0, 0, 0, 2'b00, 1'b1);
    do_read("rd_after_to", 7'h44, 0, 0, 32'h5555_AAAA, 2'b00);
    do_read("rd_edge_wins", 7'h30, 0, 13, 32'h7777_1111, 2'b00);

    // Reset while waiting for the write response.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 7'h20; cmd_wdata = 32'hFFFF_0000; cmd_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    slave_idle();
    chk("rst_mid_bready", 32'(bready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_after_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_after_cmd_ready", 32'(cmd_ready), 32'd1);
    end
    do_read("rd_after_rst", 7'h3C, 1, 2, 32'h600D_CAFE, 2'b00);

    // Randomized transactions with small slave delays.
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        do_write("rnd_wr", 7'($urandom_range(0, 127)), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 2'($urandom_range(0, 3)), 1'b0);
      end else begin
        do_read("rnd_rd", 7'($urandom_range(0, 127)), $urandom_range(0, 3),
                $urandom_range(0, 4), $urandom, 2'($urandom_range(0, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
